// File: rtl/dual_edge_gen.sv
`default_nettype none
// ============================================================================
//  Module      : dual_edge_gen
//  Description : Converts single-cycle event requests into level toggles on
//                o_dout, one toggle per accepted event, with every level held
//                for at least HOLD_CYC cycles so a downstream dual-edge
//                detector sees exactly one edge per event. Events that arrive
//                while a level is still being held are queued in a saturating
//                pending counter.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    HOLD_CYC  minimum cycles o_dout holds a level after a toggle (1..255)
//    PEND_W    pending-counter width; max pending count is 2^PEND_W-1
//  Ports
//    clk       clock, rising-edge active
//    rst_n     asynchronous active-low reset
//    i_ev_in   event request, one event per high sample
//    o_dout    registered output level, toggles once per accepted event
//    o_pend    accepted events not yet emitted
//    o_busy    high while holding a level or events are pending
//    o_ovf     sticky overflow flag (only with DUAL_EDGE_GEN_OVF_EN)
//  Build option
//    DUAL_EDGE_GEN_OVF_EN  when defined, adds the o_ovf port and its sticky
//                          register; otherwise overflowing events are
//                          dropped silently.
// ============================================================================
module dual_edge_gen #(
    parameter int HOLD_CYC = 2,
    parameter int PEND_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_ev_in,
    output logic              o_dout,
    output logic [PEND_W-1:0] o_pend,
`ifdef DUAL_EDGE_GEN_OVF_EN
    output logic              o_ovf,
`endif
    output logic              o_busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [7:0]        c_HOLD_RELOAD = 8'(HOLD_CYC - 1);
    localparam logic [PEND_W-1:0] c_PEND_MAX    = '1;

    state_t            r_state;
    logic [7:0]        r_hcnt;
    logic              r_dout;
    logic [PEND_W-1:0] r_pend;

    logic              w_work;
    logic              w_consume;
    logic              w_sat;
    logic [PEND_W-1:0] w_pend_nxt;

    assign w_work    = (r_pend != '0) | i_ev_in;
    // A toggle is allowed from IDLE, or from HOLD once the hold time expired.
    assign w_consume = w_work & ((r_state == ST_IDLE) | (r_hcnt == 8'd0));
    // Full counter, new event and nothing leaving: the event is dropped.
    assign w_sat     = (r_pend == c_PEND_MAX) & i_ev_in & ~w_consume;

    // consume without ev_in implies pend != 0, so the subtraction never
    // underflows; saturation covers the only overflow case.
    always_comb begin
        w_pend_nxt = r_pend;
        if (!w_sat) begin
            w_pend_nxt = r_pend + PEND_W'(i_ev_in) - PEND_W'(w_consume);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_hcnt  <= 8'd0;
            r_dout  <= 1'b0;
            r_pend  <= '0;
        end else begin
            r_pend <= w_pend_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_work) begin
                        r_dout  <= ~r_dout;
                        r_hcnt  <= c_HOLD_RELOAD;
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (r_hcnt != 8'd0) begin
                        r_hcnt <= r_hcnt - 8'd1;
                    end else if (w_work) begin
                        r_dout <= ~r_dout;
                        r_hcnt <= c_HOLD_RELOAD;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DUAL_EDGE_GEN_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_sat) begin
            r_ovf <= 1'b1;
        end
    end

    assign o_ovf = r_ovf;
`endif

    assign o_dout = r_dout;
    assign o_pend = r_pend;
    // Derived purely from registers, so it clears together with reset.
    assign o_busy = (r_state == ST_HOLD) | (r_pend != '0);

endmodule
`default_nettype wire
